// File: rtl/apb_arb_pkg.sv
`default_nettype none
//============================================================================
// apb_arb_pkg
// Shared types, bus widths and sizing helpers for apb_req_arbiter.
//   c_aw / c_dw / c_sw / c_pw : address, data, strobe and prot widths
//   arb_state_t               : transfer FSM state encoding
//   clog2 / timer_width       : sizing helpers for the index and the timer
// Revision: 1.0 - initial release
//============================================================================
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_arb_pkg;

  localparam int c_aw = `APB_ADDR_WIDTH;
  localparam int c_dw = `APB_DATA_WIDTH;
  localparam int c_sw = c_dw / 8;
  localparam int c_pw = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Timer must represent 0..TIMEOUT; never narrower than one bit so the
  // register still exists when the timeout is disabled.
  function automatic int timer_width(input int timeout);
    int w;
    w = clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of a requester index.
  function automatic int idx_width(input int n);
    int w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
//============================================================================
// apb_rr_arbiter
// Purely combinational round-robin picker. The search starts at i_ptr and
// wraps past NUM_REQ-1 back to 0; the first asserted request wins.
//   i_req   in  NUM_REQ  request vector
//   i_ptr   in  IW       index where the search begins (< NUM_REQ)
//   o_grant out NUM_REQ  one-hot winner (zero when no request)
//   o_idx   out IW       winner index
//   o_valid out 1        any request present
// Revision: 1.0 - initial release
//============================================================================
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  // One extra bit holds ptr+k before wrapping (at most 2*NUM_REQ-2).
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      w_pos = w_sum[IW-1:0];
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/definition.sv
`default_nettype none
//============================================================================
// definition.sv
// Global APB bus widths shared by the arbiter package and its users.
// Revision: 1.0 - initial release
//============================================================================
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
//============================================================================
// apb_req_arbiter
// Serialises NUM_REQ requesters onto one APB-style master port.
// One transfer at a time: IDLE (grant) -> ACCESS (m_sel high until m_ready
// or timeout) -> RESP (one-cycle rsp_valid) -> IDLE.
//   clk, rstn               clock, synchronous active-low reset
//   req_valid/addr/write/
//   wdata/strb/prot   in    packed per-requester request payloads
//   req_ready         out   one-hot acceptance pulse (combinational)
//   rsp_valid         out   one-hot completion pulse
//   rsp_rdata/error   out   shared response, held until the next RESP
//   m_sel/write/addr/
//   wdata/strb/prot   out   master command
//   m_ready/rdata/error in  master completion
// Revision: 1.0 - initial release
//============================================================================
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*c_aw-1:0] req_addr,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*c_dw-1:0] req_wdata,
  input  logic [NUM_REQ*c_sw-1:0] req_strb,
  input  logic [NUM_REQ*c_pw-1:0] req_prot,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [c_dw-1:0]         rsp_rdata,
  output logic                    rsp_error,
  output logic                    m_sel,
  output logic                    m_write,
  output logic [c_aw-1:0]         m_addr,
  output logic [c_dw-1:0]         m_wdata,
  output logic [c_sw-1:0]         m_strb,
  output logic [c_pw-1:0]         m_prot,
  input  logic                    m_ready,
  input  logic [c_dw-1:0]         m_rdata,
  input  logic                    m_error
);

  localparam int c_iw = idx_width(NUM_REQ);
  localparam int c_tw = timer_width(TIMEOUT);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic [c_iw-1:0]    r_ptr;
  logic [c_iw-1:0]    r_gidx;
  logic [c_aw-1:0]    r_addr;
  logic               r_write;
  logic [c_dw-1:0]    r_wdata;
  logic [c_sw-1:0]    r_strb;
  logic [c_pw-1:0]    r_prot;
  logic [c_tw-1:0]    r_timer;
  logic [c_dw-1:0]    r_rdata;
  logic               r_error;

  logic [NUM_REQ-1:0] w_grant;
  logic [c_iw-1:0]    w_gidx;
  logic               w_any;
  logic               w_timeout;
  logic [c_iw-1:0]    w_ptr_nxt;
  logic [NUM_REQ-1:0] w_rsp_onehot;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (c_iw)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_any)
  );

  // r_timer holds the number of ACCESS cycles already completed, so the
  // TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_timeout = (r_timer == c_tw'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  assign w_ptr_nxt    = (r_gidx == c_iw'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
  assign w_rsp_onehot = NUM_REQ'(1) << r_gidx;

  // ------------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // FSM next state and handshake outputs. req_ready and rsp_valid are gated
  // by rstn so a reset cycle never accepts or completes anything.
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_ACCESS;
          req_ready   = rstn ? w_grant : '0;
        end
      end
      ST_ACCESS: begin
        if (m_ready || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
        rsp_valid   = rstn ? w_rsp_onehot : '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Datapath: payload capture, access timer, response capture, RR pointer.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_prot  <= '0;
      r_timer <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gidx  <= w_gidx;
            r_addr  <= req_addr[w_gidx*c_aw +: c_aw];
            r_write <= req_write[w_gidx];
            r_wdata <= req_wdata[w_gidx*c_dw +: c_dw];
            r_strb  <= req_strb[w_gidx*c_sw +: c_sw];
            r_prot  <= req_prot[w_gidx*c_pw +: c_pw];
            r_timer <= '0;
          end
        end
        ST_ACCESS: begin
          // A completion on the timeout cycle takes precedence.
          if (m_ready) begin
            r_rdata <= r_write ? '0 : m_rdata;
            r_error <= m_error;
            r_ptr   <= w_ptr_nxt;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_error <= 1'b1;
            r_ptr   <= w_ptr_nxt;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m_sel     = (r_state == ST_ACCESS);
  assign m_wdata   = (r_state == ST_ACCESS) ? r_wdata : '0;
  assign m_write   = r_write;
  assign m_addr    = r_addr;
  assign m_strb    = r_strb;
  assign m_prot    = r_prot;
  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
//============================================================================
// tb_apb_req_arbiter
// Self-checking bench: transaction-level reference model compared against
// the DUT every cycle, directed scenarios with literal expectations, then
// randomized traffic with stalls, drops and resets.
// Revision: 1.0 - initial release
//============================================================================
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int AW = c_aw;
  localparam int DW = c_dw;
  localparam int SW = c_sw;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_strb = '0;
  logic [N*3-1:0]  req_prot = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error;
  logic            m_sel;
  logic            m_write;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_strb;
  logic [2:0]      m_prot;
  logic            m_ready = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  logic            m_error = 1'b0;

  apb_req_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .m_sel     (m_sel),
    .m_write   (m_write),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_strb    (m_strb),
    .m_prot    (m_prot),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_error   (m_error)
  );

  always #5 clk = ~clk;

  // Requester side: pending requests held until accepted.
  logic [N-1:0]  pend = '0;
  logic [AW-1:0] p_addr [N];
  logic          p_wr   [N];
  logic [DW-1:0] p_wd   [N];
  logic [SW-1:0] p_st   [N];
  logic [2:0]    p_pr   [N];

  // Reference model: the transfer in flight and the held response.
  bit            mdl_ok  = 1'b0;
  bit            mdl_act = 1'b0;
  bit            mdl_rsp = 1'b0;
  int            mdl_acc = 0;
  int            mdl_idx = 0;
  int            mdl_ptr = 0;
  logic [AW-1:0] t_addr;
  logic          t_wr;
  logic [DW-1:0] t_wd;
  logic [SW-1:0] t_st;
  logic [2:0]    t_pr;
  logic [DW-1:0] mdl_rd = '0;
  logic          mdl_er = 1'b0;

  // m_sel gap tracking
  int low_run  = 0;
  bit seen_sel = 1'b0;
  bit prev_sel = 1'b0;

  // Samples of the DUT outputs for the cycle just checked.
  logic [N-1:0]  s_req_ready, s_rsp_valid;
  logic [DW-1:0] s_rsp_rdata, s_m_wdata;
  logic          s_rsp_error, s_m_sel, s_m_write;
  logic [AW-1:0] s_m_addr;
  logic [SW-1:0] s_m_strb;
  logic [2:0]    s_m_prot;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_req(input int i);
    pend[i] = 1'b1;
    p_addr[i] = AW'($urandom);
    p_wr[i]   = 1'($urandom);
    p_wd[i]   = DW'($urandom);
    p_st[i]   = SW'($urandom);
    p_pr[i]   = 3'($urandom);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic wr);
    rand_req(i);
    p_addr[i] = a;
    p_wr[i]   = wr;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]              = pend[i];
      req_addr[i*AW +: AW]      = p_addr[i];
      req_write[i]              = p_wr[i];
      req_wdata[i*DW +: DW]     = p_wd[i];
      req_strb[i*SW +: SW]      = p_st[i];
      req_prot[i*3 +: 3]        = p_pr[i];
    end
  endtask

  // One clock cycle: compare at negedge, advance the model over the coming
  // edge, return #1 after the posedge ready for new stimulus.
  task automatic step();
    int           g;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_rsp;
    bit           fin;
    @(negedge clk);
    s_req_ready = req_ready;
    s_rsp_valid = rsp_valid;
    s_rsp_rdata = rsp_rdata;
    s_rsp_error = rsp_error;
    s_m_sel     = m_sel;
    s_m_write   = m_write;
    s_m_addr    = m_addr;
    s_m_wdata   = m_wdata;
    s_m_strb    = m_strb;
    s_m_prot    = m_prot;

    g = rr_pick(mdl_ptr, req_valid);
    e_ready = '0;
    if (rstn && !mdl_act && !mdl_rsp && g >= 0) e_ready[g] = 1'b1;
    e_rsp = '0;
    if (rstn && mdl_rsp) e_rsp[mdl_idx] = 1'b1;

    if (mdl_ok) begin
      chk("req_ready", s_req_ready, e_ready);
      chk("rsp_valid", s_rsp_valid, e_rsp);
      chk("m_sel", s_m_sel, mdl_act);
      chk("m_wdata", s_m_wdata, mdl_act ? t_wd : '0);
      if (mdl_act) begin
        chk("m_addr", s_m_addr, t_addr);
        chk("m_write", s_m_write, t_wr);
        chk("m_strb", s_m_strb, t_st);
        chk("m_prot", s_m_prot, t_pr);
      end
      chk("rsp_rdata", s_rsp_rdata, mdl_rd);
      chk("rsp_error", s_rsp_error, mdl_er);
      if (s_m_sel && !prev_sel && seen_sel) chk("msel_gap", (low_run >= 2), 1'b1);
      if (s_m_sel) begin
        seen_sel = 1'b1;
        low_run  = 0;
      end else begin
        low_run++;
      end
      prev_sel = s_m_sel;
      pend = pend & ~s_req_ready;
    end

    fin = 1'b0;
    if (!rstn) begin
      mdl_ok   = 1'b1;
      mdl_act  = 1'b0;
      mdl_rsp  = 1'b0;
      mdl_ptr  = 0;
      mdl_rd   = '0;
      mdl_er   = 1'b0;
      seen_sel = 1'b0;
      prev_sel = 1'b0;
      low_run  = 0;
    end else if (mdl_ok) begin
      if (mdl_rsp) begin
        mdl_rsp = 1'b0;
      end else if (mdl_act) begin
        mdl_acc++;
        if (m_ready) begin
          mdl_rd = t_wr ? '0 : m_rdata;
          mdl_er = m_error;
          fin    = 1'b1;
        end else if (TO > 0 && mdl_acc == TO) begin
          mdl_rd = '0;
          mdl_er = 1'b1;
          fin    = 1'b1;
        end
        if (fin) begin
          mdl_act = 1'b0;
          mdl_rsp = 1'b1;
          mdl_ptr = (mdl_idx + 1) % N;
        end
      end else if (g >= 0) begin
        mdl_act = 1'b1;
        mdl_acc = 0;
        mdl_idx = g;
        t_addr  = p_addr[g];
        t_wr    = p_wr[g];
        t_wd    = p_wd[g];
        t_st    = p_st[g];
        t_pr    = p_pr[g];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < N; i++) rand_req(i);
    drive();
    step();
    step();
    chk("rst_req_ready", s_req_ready, '0);
    chk("rst_rsp_valid", s_rsp_valid, '0);
    chk("rst_m_sel", s_m_sel, 1'b0);
    chk("rst_rsp_rdata", s_rsp_rdata, '0);
    chk("rst_rsp_error", s_rsp_error, 1'b0);
    pend = '0;
    rstn = 1'b1;
  endtask

  int nacc;
  bit got;
  int order[$];
  int exp2[5] = '{0, 1, 2, 3, 0};
  int stall;

  initial begin
    for (int i = 0; i < N; i++) rand_req(i);
    pend = '0;

    // Single read from requester 1, m_ready two cycles after m_sel.
    do_reset();
    set_req(1, 'h10, 1'b0);
    m_rdata = 32'hA5A5_0001;
    m_error = 1'b0;
    nacc = 0;
    got  = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      m_ready = (nacc == 2);
      drive();
      step();
      if (c == 0) chk("t1_req_ready", s_req_ready, 4'b0010);
      if (s_m_sel) begin
        if (nacc == 0) chk("t1_m_addr", s_m_addr, 'h10);
        nacc++;
      end
      if (s_rsp_valid != 0) begin
        got = 1'b1;
        chk("t1_rsp_valid", s_rsp_valid, 4'b0010);
        chk("t1_rsp_rdata", s_rsp_rdata, 32'hA5A5_0001);
        chk("t1_rsp_error", s_rsp_error, 1'b0);
      end
    end
    chk("t1_rsp_seen", got, 1'b1);
    m_ready = 1'b0;

    // All requesters valid continuously: strict rotation from 0.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_req(i);
    order.delete();
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      drive();
      step();
      for (int i = 0; i < N; i++) if (s_req_ready[i]) order.push_back(i);
      for (int i = 0; i < N; i++) if (!pend[i]) rand_req(i);
    end
    chk("t2_grant_count", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++)
      chk($sformatf("t2_grant%0d", k), order[k], exp2[k]);
    pend = '0;
    m_ready = 1'b0;

    // Write with m_ready never asserted: timeout after 16 ACCESS cycles.
    do_reset();
    set_req(3, 'h40, 1'b1);
    nacc = 0;
    got  = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      drive();
      step();
      if (s_m_sel) nacc++;
      if (s_rsp_valid != 0) begin
        got = 1'b1;
        chk("t3_rsp_valid", s_rsp_valid, 4'b1000);
        chk("t3_rsp_error", s_rsp_error, 1'b1);
        chk("t3_rsp_rdata", s_rsp_rdata, '0);
      end
    end
    chk("t3_rsp_seen", got, 1'b1);
    chk("t3_sel_cycles", nacc, 16);

    // m_ready with m_error on the 16th ACCESS cycle: normal completion.
    set_req(0, 'h80, 1'b0);
    m_rdata = 32'h1234_5678;
    nacc = 0;
    got  = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      m_ready = (nacc == 15);
      m_error = (nacc == 15);
      drive();
      step();
      if (s_m_sel) nacc++;
      if (s_rsp_valid != 0) begin
        got = 1'b1;
        chk("t4_rsp_valid", s_rsp_valid, 4'b0001);
        chk("t4_rsp_error", s_rsp_error, 1'b1);
        chk("t4_rsp_rdata", s_rsp_rdata, 32'h1234_5678);
      end
    end
    chk("t4_rsp_seen", got, 1'b1);
    chk("t4_sel_cycles", nacc, 16);
    m_ready = 1'b0;
    m_error = 1'b0;

    // Reset mid-ACCESS of requester 2: abort, pointer back to 0.
    do_reset();
    m_ready = 1'b1;
    set_req(1, 'h20, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      drive();
      step();
      if (s_rsp_valid != 0) got = 1'b1;
    end
    chk("t5_pre_seen", got, 1'b1);
    m_ready = 1'b0;
    set_req(2, 'hC0, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      drive();
      step();
      if (s_m_sel) got = 1'b1;
    end
    chk("t5_access_seen", got, 1'b1);
    rstn = 1'b0;
    drive();
    step();
    rstn = 1'b1;
    drive();
    step();
    chk("t5_m_sel_drop", s_m_sel, 1'b0);
    chk("t5_no_rsp", s_rsp_valid, '0);
    set_req(0, 'h00, 1'b0);
    set_req(3, 'h30, 1'b0);
    m_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      drive();
      step();
      if (s_req_ready != 0) begin
        got = 1'b1;
        chk("t5_grant", s_req_ready, 4'b0001);
      end else begin
        chk("t5_no_rsp_wait", s_rsp_valid, '0);
      end
    end
    chk("t5_grant_seen", got, 1'b1);

    // Randomized traffic: new requests, drops, stalls, errors, resets.
    do_reset();
    stall = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) stall = int'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) rand_req(i);
        end else if ($urandom_range(0, 39) == 0) begin
          pend[i] = 1'b0;
        end
      end
      m_ready = stall ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      m_rdata = DW'($urandom);
      m_error = ($urandom_range(0, 7) == 0);
      rstn    = ($urandom_range(0, 149) != 0);
      drive();
      step();
    end
    rstn = 1'b1;
    pend = '0;
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
